act_packer: RTL and testbench
=============================

ACT_PACKER -- requirements
Module: act_packer

Interface
REQ-001 SHALL have parameter N_OUT, default 62, meaning number of 8-bit activations per packed output vector (2..62).
REQ-002 SHALL have parameter SHIFT, default 7, meaning right-shift applied to the 20-bit magnitude before saturation (0..19).
REQ-003 SHALL have parameter RELU, default 1, meaning 1 = negative results forced to zero, 0 = sign kept.
REQ-004 SHALL have port clk  input  1  rising-edge clock; sole clock domain.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_data holds a MAC result.
REQ-007 SHALL have port in_ready  output  1  block can accept a result this cycle.
REQ-008 SHALL have port in_data  input  21  sign-magnitude MAC result: bit 20 sign (1 = negative), bits 19:0 magnitude.
REQ-009 SHALL have port flush  input  1  single-cycle request to close a partial vector.
REQ-010 SHALL have port out_valid  output  1  out_data holds a complete packed vector.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 SHALL have port out_data  output  N_OUT*8  packed sign-magnitude activations; element i at bits 8i+7:8i, bit 8i+7 sign.
REQ-013 SHALL have port count  output  6  number of elements stored in the current vector.

Function
REQ-014 SHALL implement two states: COLLECT (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1).
REQ-015 SHALL accept an input on a rising edge where in_valid=1 and in_ready=1; other cycles store nothing.
REQ-016 SHALL compute the stored byte as: m = magnitude >> SHIFT (truncate); mag7 = 127 if m > 127 else m[6:0].
REQ-017 SHALL set the byte to 8'h00 when RELU=1 and the sign bit is 1, regardless of magnitude.
REQ-018 SHALL, when RELU=0, set the byte to {sign, mag7}, except mag7 = 0 yields 8'h00 (no negative zero).
REQ-019 SHALL write each accepted byte to element index count, then increment count by 1.
REQ-020 SHALL enter FULL on the edge accepting the N_OUT-th element; count then equals N_OUT.
REQ-021 SHALL enter FULL on a flush edge in COLLECT with count > 0, zero-filling elements count..N_OUT-1; count is kept.
REQ-022 SHALL, when flush and an accepted input coincide, store the input first, then zero-fill the remainder and enter FULL.
REQ-023 SHALL ignore flush when count = 0 with no input accepted that cycle, and ignore flush in FULL.
REQ-024 SHALL hold out_data and count stable for as long as out_valid=1 and out_ready=0.
REQ-025 SHALL, on an edge with out_valid=1 and out_ready=1, return to COLLECT, clear count to 0 and clear out_data to all zeros.
REQ-026 SHALL not accept input in the handshake cycle; the earliest next acceptance is the following cycle (one bubble).
REQ-027 SHALL have in_ready, out_valid and count as registered outputs, and out_data driven directly from the element register array.
REQ-028 SHALL be synthesizable with no combinational path from in_valid or out_ready to in_ready or out_valid.

Reset
REQ-029 SHALL, on a clk edge with rst_n=0, enter COLLECT with count=0, out_data=0, out_valid=0 and in_ready=1.
REQ-030 SHALL, on reset mid-vector or while in FULL, discard all stored elements with no output handshake.
REQ-031 SHALL ignore in_valid, flush and out_ready on any edge where rst_n=0.

Verification
REQ-032 SHALL verify quantization (N_OUT=62, SHIFT=7, RELU=1): in_data 0x00280 -> byte 0x05; 0x0FFFFF -> 0x7F; 0x100280 -> 0x00; 0x00050 -> 0x00.
REQ-033 SHALL verify sign handling with RELU=0: 0x100280 -> 0x85; 0x100050 -> 0x00.
REQ-034 SHALL verify the full vector: 62 back-to-back inputs with value i<<7 for i = 0..61 -> out_valid on edge 62, byte i = i, in_ready=0.
REQ-035 SHALL verify backpressure and release: out_ready=0 for 10 cycles -> out_data and count stable; out_ready=1 -> next cycle count=0, in_ready=1, out_data=0.
REQ-036 SHALL verify flush with a coinciding input: 3 inputs, then a 4th with flush=1 -> FULL, count=4, bytes 4..61 = 0x00.
REQ-037 SHALL verify reset: rst_n=0 for one edge after 20 inputs -> count=0, out_valid=0, out_data=0, and the next 62 inputs form a clean vector.

Source files
------------

// File: rtl/act_packer.sv
// act_packer: quantizes sign-magnitude MAC results to 8-bit activations and packs them into N_OUT-wide vectors.
module act_packer #(
    parameter int N_OUT = 62,
    parameter int SHIFT = 7,
    parameter int RELU  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [20:0]        in_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_OUT*8-1:0] out_data,
    output logic [5:0]         count
);
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] FULL    = 1'b1;
    logic [0:0]  state;
    logic [19:0] m;
    logic [6:0]  mag7;
    logic [7:0]  q_byte;
    logic        accept;
    logic        hs;
    logic        close;
    always_comb begin
        m      = in_data[19:0] >> SHIFT;
        mag7   = |m[19:7] ? 7'h7f : m[6:0];
        q_byte = ((RELU != 0 && in_data[20]) || mag7 == 7'd0) ? 8'h00 : {in_data[20], mag7};
        accept = in_valid && in_ready;
        hs     = out_valid && out_ready;
        close  = (accept && count == 6'(N_OUT - 1)) || (flush && (accept || count != 6'd0));
    end
    // Unwritten elements are already zero (cleared on reset and handshake), so a flush needs no explicit fill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= 6'd0;
            out_data  <= '0;
        end else if (state == FULL) begin
            if (hs) begin
                state     <= COLLECT;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
                count     <= 6'd0;
                out_data  <= '0;
            end
        end else begin
            if (accept) begin
                out_data[8*count +: 8] <= q_byte;
                count                  <= count + 6'd1;
            end
            if (close) begin
                state     <= FULL;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_act_packer.sv
// tb_act_packer: randomized scoreboard bench for act_packer with a queue-based reference model.
module tb_act_packer;
    localparam int N  = 62;
    localparam int SH = 7;
    localparam int W  = N * 8;
    localparam int N2 = 4;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [20:0] in_data = '0;
    logic in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [5:0] count;
    logic in_valid2 = 1'b0, flush2 = 1'b0, out_ready2 = 1'b0;
    logic [20:0] in_data2 = '0;
    logic in_ready2, out_valid2;
    logic [N2*8-1:0] out_data2;
    logic [5:0] count2;
    always #5 clk = ~clk;
    act_packer #(.N_OUT(N), .SHIFT(SH), .RELU(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count)
    );
    act_packer #(.N_OUT(N2), .SHIFT(7), .RELU(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .flush(flush2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .count(count2)
    );
    typedef struct {
        logic [W-1:0] data;
        logic [5:0]   cnt;
    } exp_t;
    exp_t exp_q[$];
    logic [7:0] cur[$];
    int checks = 0;
    int errors = 0;
    bit done = 0;
    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask
    function automatic logic [7:0] quant(input logic [20:0] d);
        int mv;
        mv = int'(d[19:0]) / (1 << SH);
        if (mv > 127) mv = 127;
        if (mv == 0 || d[20]) return 8'h00;
        return 8'(mv);
    endfunction
    function automatic void close_vec();
        exp_t e;
        e.data = '0;
        foreach (cur[i]) e.data[8*i +: 8] = cur[i];
        e.cnt = 6'(cur.size());
        exp_q.push_back(e);
        cur.delete();
    endfunction
    task automatic send(input logic [20:0] d, input logic fl);
        bit acc = 0;
        bit r;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk) r = in_ready;
            @(posedge clk);
            if (r) begin
                acc = 1;
                cur.push_back(quant(d));
                if (cur.size() == N || fl) close_vec();
            end
        end
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 for 200 cycles, required 1");
        end
    endtask
    task automatic flush_only();
        bit r;
        flush = 1'b1;
        @(negedge clk) r = in_ready;
        @(posedge clk);
        if (r && cur.size() > 0) close_vec();
        #1;
        flush = 1'b0;
    endtask
    function automatic logic [20:0] rnd_in();
        logic [20:0] d;
        d[20]   = 1'($urandom_range(0, 1));
        d[19:0] = 20'($urandom >> $urandom_range(4, 24));
        return d;
    endfunction
    // Scoreboard monitor: every completed output handshake consumes one modelled vector.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vector: got count %0d, required no vector", count);
            end else begin
                e = exp_q.pop_front();
                chk("vec_data", out_data, e.data);
                chk("vec_count", count, e.cnt);
            end
        end
    end
    initial begin
        logic [W-1:0] ramp;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 6'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        in_valid2 = 1'b1;
        in_data2 = 21'h100280;
        @(posedge clk) #1;
        in_data2 = 21'h100050;
        @(posedge clk) #1;
        in_data2 = 21'h1FFFFF;
        flush2 = 1'b1;
        @(posedge clk) #1;
        in_valid2 = 1'b0;
        flush2 = 1'b0;
        chk("signed_out_valid", out_valid2, 1'b1);
        chk("signed_bytes", out_data2, 32'h00FF0085);
        chk("signed_count", count2, 6'd3);
        out_ready2 = 1'b1;
        @(posedge clk) #1;
        out_ready2 = 1'b0;
        chk("signed_release_data", out_data2, 32'h0);
        chk("signed_release_count", count2, 6'd0);
        send(21'h00280, 1'b0);
        send(21'h0FFFFF, 1'b0);
        send(21'h100280, 1'b0);
        send(21'h00050, 1'b1);
        chk("quant_out_valid", out_valid, 1'b1);
        chk("quant_b0", out_data[7:0], 8'h05);
        chk("quant_b1", out_data[15:8], 8'h7F);
        chk("quant_b2", out_data[23:16], 8'h00);
        chk("quant_b3", out_data[31:24], 8'h00);
        out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(21'(i << 7), 1'b0);
        for (int i = 0; i < N; i++) ramp[8*i +: 8] = 8'(i);
        chk("full_out_valid", out_valid, 1'b1);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_count", count, 6'd62);
        chk("full_ramp", out_data, ramp);
        repeat (10) begin
            @(posedge clk) #1;
            chk("hold_data", out_data, exp_q[0].data);
            chk("hold_count", count, 6'd62);
        end
        out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;
        chk("release_count", count, 6'd0);
        chk("release_in_ready", in_ready, 1'b1);
        chk("release_out_valid", out_valid, 1'b0);
        chk("release_data", out_data, '0);
        repeat (3) send(rnd_in(), 1'b0);
        send(rnd_in(), 1'b1);
        chk("flush_out_valid", out_valid, 1'b1);
        chk("flush_count", count, 6'd4);
        chk("flush_zero_fill", out_data[W-1:32], '0);
        out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;
        flush_only();
        chk("empty_flush_valid", out_valid, 1'b0);
        chk("empty_flush_count", count, 6'd0);
        repeat (20) send(rnd_in(), 1'b0);
        rst_n = 1'b0;
        @(posedge clk) #1;
        rst_n = 1'b1;
        cur.delete();
        chk("midrst_count", count, 6'd0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, '0);
        out_ready = 1'b1;
        repeat (N) send(rnd_in(), 1'b0);
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    if ($urandom_range(0, 3) == 0) @(posedge clk) #1;
                    if ($urandom_range(0, 24) == 0) flush_only();
                    else send(rnd_in(), $urandom_range(0, 15) == 0);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk) #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int t = 0; t < 50 && cur.size() > 0; t++) flush_only();
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(posedge clk) #1;
        if (cur.size() > 0 || exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending vectors, required 0", exp_q.size() + (cur.size() > 0 ? 1 : 0));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
